// File: rtl/serial_sub.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
// One full-subtractor cell plus borrow flop, operand shifters and a 3-state controller.
//
// state | meaning
// IDLE  | waiting for start; d/bo/ov hold the last result
// SHIFT | one difference bit per cycle, WIDTH cycles
// DONE  | one-cycle done pulse; d/bo/ov freshly loaded
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ov,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_n;
    logic             br;
    logic             br_n;
    logic             diff_bit;
    logic             a_msb;
    logic             b_msb;
    logic             last;
    logic [CW-1:0]    cnt;

    // Full-subtractor cell on the current LSBs of the operand shifters.
    always_comb begin
        diff_bit = a_sh[0] ^ b_sh[0] ^ br;
        br_n     = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_n    = {diff_bit, res[WIDTH-1:1]};
        last     = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            d     <= '0;
            bo    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= br_n;
                    res  <= res_n;
                    cnt  <= cnt + CW'(1);
                    // Publish on the final bit so d/bo/ov are valid throughout DONE.
                    if (last) begin
                        d  <= res_n;
                        bo <= br_n;
                        ov <= (a_msb != b_msb) && (diff_bit != a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: WIDTH=8 directed/random ops and a WIDTH=4 exhaustive sweep.
// Expected results come from plain integer arithmetic; monitors pop them on each done pulse.
module tb_serial_sub;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic [7:0] d8;
    logic       bo8;
    logic       ov8;
    logic       busy8;
    logic       done8;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       bin4;
    logic [3:0] d4;
    logic       bo4;
    logic       ov4;
    logic       busy4;
    logic       done4;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 0;

    exp_t q8[$];
    exp_t q4[$];
    exp_t e8;
    exp_t e4;
    int   pushed8 = 0;
    int   pushed4 = 0;
    int   done_cnt8 = 0;
    int   done_cnt4 = 0;
    int   run8 = 0;
    int   run4 = 0;
    int   last4 = -1;
    logic [9:0] held8 = '0;
    logic [5:0] held4 = '0;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .d(d8), .bo(bo8), .ov(ov8), .busy(busy8), .done(done8)
    );

    serial_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .d(d4), .bo(bo4), .ov(ov4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: unsigned wrap for d, unsigned compare for borrow, signed range for overflow.
    function automatic exp_t model(input int w, input int a, input int b, input int bin, input int c);
        exp_t e;
        int   sa;
        int   sb;
        int   sd;
        e.d   = 8'((a - b - bin) & ((1 << w) - 1));
        e.bo  = (a < b + bin);
        sa    = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb    = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        sd    = sa - sb - bin;
        e.ov  = (sd < -(1 << (w - 1))) || (sd > (1 << (w - 1)) - 1);
        e.cyc = c;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        bin8   = bin;
        q8.push_back(model(8, int'(a), int'(b), int'(bin), cyc));
        pushed8++;
        step();
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        bin8   = 1'($urandom);
        repeat (9) step();
    endtask

    // done is expected in the (WIDTH+2)th cycle counting the start cycle as the first.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) run8 = 0;
            else if (busy8) run8++;
            if (done8) begin
                done_cnt8++;
                if (q8.size() == 0) begin
                    chk("w8_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e8 = q8.pop_front();
                    chk("w8_d", 32'(d8), 32'(e8.d));
                    chk("w8_bo", 32'(bo8), 32'(e8.bo));
                    chk("w8_ov", 32'(ov8), 32'(e8.ov));
                    chk("w8_latency", 32'(cyc - e8.cyc), 32'd9);
                    chk("w8_busy_cycles", 32'(run8), 32'd8);
                end
                run8  = 0;
                held8 = {d8, bo8, ov8};
            end else begin
                chk("w8_hold", 32'({d8, bo8, ov8}), 32'(held8));
                if (rst) held8 = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) run4 = 0;
            else if (busy4) run4++;
            if (done4) begin
                done_cnt4++;
                if (q4.size() == 0) begin
                    chk("w4_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e4 = q4.pop_front();
                    chk("w4_d", 32'(d4), 32'(e4.d[3:0]));
                    chk("w4_bo", 32'(bo4), 32'(e4.bo));
                    chk("w4_ov", 32'(ov4), 32'(e4.ov));
                    chk("w4_latency", 32'(cyc - e4.cyc), 32'd5);
                    chk("w4_busy_cycles", 32'(run4), 32'd4);
                end
                if (last4 >= 0) chk("w4_spacing", 32'(cyc - last4), 32'd6);
                last4 = cyc;
                run4  = 0;
                held4 = {d4, bo4, ov4};
            end else begin
                chk("w4_hold", 32'({d4, bo4, ov4}), 32'(held4));
                if (rst) held4 = '0;
            end
        end
    end

    initial begin
        int snap;
        rst    = 1'b1;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        bin8   = 1'b0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        bin4   = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_d", 32'(d8), 32'd0);
        chk("reset_bo", 32'(bo8), 32'd0);
        chk("reset_ov", 32'(ov8), 32'd0);
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        chk("reset_d4", 32'(d4), 32'd0);
        mon_en = 1'b1;

        do_op8(8'h05, 8'h03, 1'b0);

        // Abort in the 4th SHIFT cycle; nothing is pushed for this op.
        start8 = 1'b1;
        a8     = 8'h33;
        b8     = 8'h11;
        bin8   = 1'b0;
        step();
        start8 = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_done", 32'(done8), 32'd0);
        chk("midrst_d", 32'(d8), 32'd0);
        chk("midrst_bo", 32'(bo8), 32'd0);
        chk("midrst_ov", 32'(ov8), 32'd0);

        do_op8(8'h03, 8'h05, 1'b0);
        do_op8(8'h00, 8'hFF, 1'b1);
        do_op8(8'h80, 8'h01, 1'b0);
        do_op8(8'h7F, 8'hFF, 1'b0);
        do_op8(8'h00, 8'h00, 1'b1);
        do_op8(8'h5A, 8'h5A, 1'b0);
        do_op8(8'h80, 8'h00, 1'b1);

        // start re-asserted during SHIFT with new operands must be ignored.
        snap   = done_cnt8;
        start8 = 1'b1;
        a8     = 8'h10;
        b8     = 8'h01;
        bin8   = 1'b0;
        q8.push_back(model(8, 'h10, 'h01, 0, cyc));
        pushed8++;
        step();
        start8 = 1'b0;
        repeat (2) step();
        start8 = 1'b1;
        a8     = 8'hAA;
        repeat (3) step();
        start8 = 1'b0;
        repeat (6) step();
        chk("ignored_start_one_done", 32'(done_cnt8 - snap), 32'd1);

        repeat (30) do_op8(8'($urandom), 8'($urandom), 1'($urandom));

        // Exhaustive WIDTH=4 sweep with start held high; operands scrambled mid-op.
        start4 = 1'b1;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a4   = 4'(ai);
                    b4   = 4'(bi);
                    bin4 = 1'(ci);
                    q4.push_back(model(4, ai, bi, ci, cyc));
                    pushed4++;
                    repeat (2) step();
                    a4   = 4'($urandom);
                    b4   = 4'($urandom);
                    bin4 = 1'($urandom);
                    repeat (4) step();
                end
            end
        end
        start4 = 1'b0;

        for (int i = 0; i < 40 && (q8.size() != 0 || q4.size() != 0); i++) step();
        repeat (2) step();
        chk("w8_queue_drained", 32'(q8.size()), 32'd0);
        chk("w4_queue_drained", 32'(q4.size()), 32'd0);
        chk("w8_done_count", 32'(done_cnt8), 32'(pushed8));
        chk("w4_done_count", 32'(done_cnt4), 32'd512);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
